// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single combinational ALU.
// One request is accepted at a time. Its operands are registered, the ALU is
// evaluated for one cycle, and the result is returned on one response channel
// together with the ID of the requester that issued it.

// Combinational ALU shared by both requesters.
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A<<1, 7 A>>1.
module alu #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] alu_out
);
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR = OPW'(7);

    // Result selection; sums and differences simply wrap at WIDTH bits.
    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD:  alu_out = A + B;
            OP_SUB:  alu_out = A - B;
            OP_AND:  alu_out = A & B;
            OP_OR:   alu_out = A | B;
            OP_XOR:  alu_out = A ^ B;
            OP_NOT:  alu_out = ~A;
            OP_SHL:  alu_out = {A[WIDTH-2:0], 1'b0};
            OP_SHR:  alu_out = {1'b0, A[WIDTH-1:1]};
            default: alu_out = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_id_q, rsp_id_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] alu_out;

    // The ALU only ever sees the operand registers, so its inputs are
    // quiet (zero) after reset and independent of the request ports.
    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .A       (a_q),
        .B       (b_q),
        .op      (op_q),
        .alu_out (alu_out)
    );

    // Next-state logic: grant selection in IDLE, result capture in EXEC,
    // response handshake in RESP.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        rsp_out_d = rsp_out_q;
        rsp_id_d  = rsp_id_q;
        cnt_d     = cnt_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Readies are masked during reset so every output reads 0.
                if (!rst) begin
                    if (req0_valid && (!req1_valid || !ptr_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0) begin
                    a_d     = req0_A;
                    b_d     = req0_B;
                    op_d    = req0_op;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    state_d = S_EXEC;
                end else if (gnt1) begin
                    a_d     = req1_A;
                    b_d     = req1_B;
                    op_d    = req1_op;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_out_d = alu_out;
                rsp_id_d  = id_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                // Acceptance of the next request waits for the IDLE cycle.
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            rsp_out_q <= '0;
            rsp_id_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            id_q      <= id_d;
            rsp_out_q <= rsp_out_d;
            rsp_id_q  <= rsp_id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state_q == S_RESP);
    assign busy       = (state_q == S_EXEC) || (state_q == S_RESP);
    assign rsp_out    = rsp_out_q;
    assign rsp_id     = rsp_id_q;
    assign op_count   = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model (queue of expected
// results with due cycles) checked every cycle, plus literal spot checks.
module tb_alu_arbiter;
    logic       clk;
    logic       rst;
    logic       v0, v1, r0, r1;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0] rsp_out;
    logic [7:0] op_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    alu_arbiter #(.WIDTH(4), .OPW(3), .CNTW(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_A(a0), .req0_B(b0), .req0_op(op0),
        .req1_valid(v1), .req1_ready(r1), .req1_A(a1), .req1_B(b1), .req1_op(op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .busy(busy), .op_count(op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return 4'((a * 2) % 16);
            default: return a / 2;
        endcase
    endfunction

    // Model: each accepted request becomes an expected result that appears
    // two cycles after acceptance and leaves when consumed.
    typedef struct {
        logic       id;
        logic [3:0] res;
        int         due;
    } exp_t;
    exp_t q[$];
    int         cyc = 0;
    logic       m_ptr = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    logic [3:0] m_out = 4'd0;
    logic       m_id = 1'b0;

    function automatic logic grant_side(input logic ptr);
        if (v0 && v1) return ptr;
        return v0 ? 1'b0 : 1'b1;
    endfunction

    // Model update at each rising edge, using the inputs of the ending cycle.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ptr = 1'b0;
            m_cnt = 8'd0;
            m_out = 4'd0;
            m_id  = 1'b0;
        end else begin
            bit   was_free;
            logic g;
            exp_t e;
            was_free = (q.size() == 0);
            if (q.size() > 0 && cyc == q[0].due - 1) begin
                m_out = q[0].res;
                m_id  = q[0].id;
            end
            if (q.size() > 0 && cyc >= q[0].due && rsp_ready) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 8'd1;
            end
            if (was_free && (v0 || v1)) begin
                g = grant_side(m_ptr);
                e.id  = g;
                e.res = g ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
                e.due = cyc + 2;
                q.push_back(e);
                m_ptr = ~g;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit   free;
            logic e_r0, e_r1;
            free = (q.size() == 0);
            e_r0 = free && !rst && v0 && (!v1 || m_ptr == 1'b0);
            e_r1 = free && !rst && v1 && (!v0 || m_ptr == 1'b1);
            chk("req0_ready", 32'(r0), 32'(e_r0));
            chk("req1_ready", 32'(r1), 32'(e_r1));
            chk("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0 && cyc >= q[0].due));
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("rsp_out", 32'(rsp_out), 32'(m_out));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("op_count", 32'(op_count), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Present a request and hold it until accepted; returns at the EXEC cycle.
    task automatic send(input int port, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bit acc;
        acc = 0;
        if (port == 0) begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
        else           begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port == 0 && r0) || (port == 1 && r1)) begin
                acc = 1;
                break;
            end
            tick();
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        tick();
        if (port == 0) v0 = 1'b0;
        else           v1 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_out"}, 32'(rsp_out), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    // After a reset: no response may appear, and a contended grant goes to req0.
    task automatic post_reset_checks(input string tag);
        bit seen;
        seen = 0;
        check_all_zero(tag);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
            tick();
        end
        chk({tag, "_no_rsp"}, 32'(seen), 32'd0);
        a0 = 4'd1; b0 = 4'd1; op0 = 3'd0;
        a1 = 4'd2; b1 = 4'd1; op1 = 3'd0;
        v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        chk({tag, "_first_grant0"}, 32'(r0), 32'd1);
        chk({tag, "_first_grant1"}, 32'(r1), 32'd0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        repeat (3) tick();
    endtask

    logic [3:0] hold_out;
    logic       hold_id;
    logic [7:0] hold_cnt;
    logic       ids[4];
    int         n;
    int         guard;
    logic [3:0] avals[3];
    logic [3:0] bvals[2];

    initial begin
        rst = 1'b1; v0 = 0; v1 = 0; rsp_ready = 1'b1;
        a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        chk("reset_ready0", 32'(r0), 32'd0);
        tick();

        // Single request: ADD 3+1 -> 4, response two cycles after acceptance.
        send(0, 4'b0011, 4'b0001, 3'b000);
        @(negedge clk);
        chk("lat_n1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(rsp_valid), 32'd1);
        chk("single_out", 32'(rsp_out), 32'h4);
        chk("single_id", 32'(rsp_id), 32'd0);
        tick();
        chk("single_count", 32'(op_count), 32'd1);
        $display("txn single: id=%0d out=%0h count=%0d", rsp_id, rsp_out, op_count);
        tick();

        // Fairness: both valid from reset, grants alternate 0,1,0,1.
        do_reset();
        a0 = 4'b0011; b0 = 4'b0001; op0 = 3'b000;
        a1 = 4'b0011; b1 = 4'b0001; op1 = 3'b001;
        v0 = 1'b1; v1 = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                ids[n] = rsp_id;
                chk("fair_out", 32'(rsp_out), rsp_id ? 32'h2 : 32'h4);
                $display("txn fair %0d: id=%0d out=%0h", n, rsp_id, rsp_out);
                n++;
            end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("fair_count", 32'(n), 32'd4);
        chk("fair_id0", 32'(ids[0]), 32'd0);
        chk("fair_id1", 32'(ids[1]), 32'd1);
        chk("fair_id2", 32'(ids[2]), 32'd0);
        chk("fair_id3", 32'(ids[3]), 32'd1);
        repeat (3) tick();

        // Backpressure: five stalled cycles in RESP with a competing request.
        rsp_ready = 1'b0;
        send(1, 4'b1111, 4'b0001, 3'b000);
        tick();
        hold_out = rsp_out; hold_id = rsp_id; hold_cnt = op_count;
        chk("bp_out_value", 32'(hold_out), 32'h0);
        chk("bp_id_value", 32'(hold_id), 32'd1);
        a0 = 4'd5; b0 = 4'd2; op0 = 3'd2; v0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_out", 32'(rsp_out), 32'(hold_out));
            chk("bp_id", 32'(rsp_id), 32'(hold_id));
            chk("bp_ready0", 32'(r0), 32'd0);
            chk("bp_count", 32'(op_count), 32'(hold_cnt));
            tick();
        end
        v0 = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_count", 32'(op_count), 32'(hold_cnt + 8'd1));
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        $display("txn backpressure: out=%0h count=%0d", hold_out, op_count);
        tick();

        // Reset while in EXEC (pointer was moved to 1 by the accept).
        send(0, 4'd7, 4'd1, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        post_reset_checks("rst_exec");
        $display("txn reset in EXEC done");

        // Reset while stalled in RESP.
        rsp_ready = 1'b0;
        send(0, 4'd7, 4'd1, 3'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        post_reset_checks("rst_resp");
        $display("txn reset in RESP done");

        // Opcode sweep; the per-cycle model checks every result.
        avals[0] = 4'b0000; avals[1] = 4'b0011; avals[2] = 4'b1111;
        bvals[0] = 4'b0001; bvals[1] = 4'b1111;
        for (int op = 0; op < 8; op++) begin
            for (int ai = 0; ai < 3; ai++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    send((op + ai + bi) % 2, avals[ai], bvals[bi], 3'(op));
                    @(negedge clk);
                    $display("txn sweep: op=%0d A=%0h B=%0h out=%0h id=%0d", op, avals[ai], bvals[bi], rsp_out, rsp_id);
                    tick();
                    tick();
                end
            end
        end

        // Counter wrap: 256 consumed operations from reset.
        do_reset();
        a0 = 4'd9; b0 = 4'd3; op0 = 3'd4; v0 = 1'b1;
        n = 0;
        guard = 0;
        while (n < 256 && guard < 1200) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) n++;
            guard++;
            tick();
        end
        chk("wrap_done", 32'(n), 32'd256);
        chk("wrap_count", 32'(op_count), 32'd0);
        v0 = 1'b0;
        @(negedge clk);
        chk("wrap_idle", 32'(busy), 32'd0);
        $display("txn wrap: consumed=%0d count=%0d", n, op_count);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
